mul_div_unit: RTL and testbench

- Iterative multiply/divide unit in the execute stage, directly downstream of reg_file.
- Consumes reg_data1 (rs) and reg_data2 (rt) and produces the architectural HI/LO pair for MULT/MULTU/DIV/DIVU.
- Also supports MTHI/MTLO writes.
- Start/busy/done handshake; the pipeline control stalls on busy before any MFHI/MFLO or new mult/div.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/mul_div_unit_sign_fix.sv | 49 ++++
 rtl/mul_div_unit.sv | 187 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
//   md_state_e : state encoding of the mul/div sequencer (exposed for debug)
//   MD_*       : two-bit operation encodings driven by the decoder
//   MD_LATENCY : clock edges from the start edge until hi/lo and done are visible
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } md_state_e;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_LATENCY = 33;

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// md_sign_fix: combinational final-sign correction for the mul/div unit.
// The iterative datapath always works on magnitudes; this block restores
// the architectural signs before hi/lo are written.
// Ports:
//   is_div   : 1 = divide result, 0 = multiply result
//   neg_a    : dividend / multiplicand was negative (signed ops only)
//   neg_b    : divisor / multiplier was negative (signed ops only)
//   div_zero : divisor was zero; quotient stays all-ones, remainder = dividend
//   prod     : unsigned 2*WIDTH product magnitude
//   quot     : unsigned quotient magnitude
//   rem      : unsigned remainder magnitude
//   hi_fix   : value for HI (product high half or remainder)
//   lo_fix   : value for LO (product low half or quotient)
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic               neg_a,
    input  logic               neg_b,
    input  logic               div_zero,
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   quot,
    input  logic [WIDTH-1:0]   rem,
    output logic [WIDTH-1:0]   hi_fix,
    output logic [WIDTH-1:0]   lo_fix
);

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;

    always_comb begin
        prod_s = (neg_a ^ neg_b) ? (~prod + 1'b1) : prod;
        // A zero divisor yields all-ones regardless of operand signs.
        quot_s = ((neg_a ^ neg_b) && !div_zero) ? (~quot + 1'b1) : quot;
        // Remainder follows the dividend; with a zero divisor this recreates
        // the original dividend exactly (including the most negative value).
        rem_s  = neg_a ? (~rem + 1'b1) : rem;

        if (is_div) begin
            hi_fix = rem_s;
            lo_fix = quot_s;
        end else begin
            hi_fix = prod_s[2*WIDTH-1:WIDTH];
            lo_fix = prod_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
// Handshake: start is sampled only in IDLE; busy is high from the edge after
// an accepted start until results are written; done pulses for exactly one
// cycle together with the new hi/lo, and that same cycle is already IDLE so a
// new start is accepted there. start outside IDLE is dropped, not queued.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, op      : operation request and encoding (cpu_pkg MD_*)
//   a, b           : rs / rt operands (dividend / divisor for divides)
//   hi_we, lo_we   : MTHI / MTLO enables, wdata is the write data (IDLE only)
//   busy, done     : status, done is a one-cycle pulse
//   hi, lo         : architectural HI / LO registers
//   dbg_state      : current sequencer state
module mul_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output md_state_e        dbg_state
);

    localparam int CNT_W = $clog2(ITER);

    md_state_e          state;
    md_state_e          state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last_iter;

    // Latched operation context
    logic               is_div_q;
    logic               neg_a_q;
    logic               neg_b_q;
    logic [WIDTH-1:0]   ma;        // multiplicand magnitude (mult)
    logic [WIDTH-1:0]   mb;        // divisor magnitude (div)

    // Shared accumulator: mult = {product high, multiplier/product low},
    // div = {partial remainder, dividend shifting into quotient}
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;

    logic               a_neg_in;
    logic               b_neg_in;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ok;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_iter = (cnt == CNT_W'(ITER - 1));
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_iter) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // ---------------- operand conditioning ----------------
    always_comb begin
        a_neg_in = ~op[0] & a[WIDTH-1];
        b_neg_in = ~op[0] & b[WIDTH-1];
        a_mag    = a_neg_in ? (~a + 1'b1) : a;
        b_mag    = b_neg_in ? (~b + 1'b1) : b;
    end

    // ---------------- iteration datapath ----------------
    always_comb begin
        // Shift-add: add the multiplicand when the current multiplier bit is
        // set, then shift the whole 2*WIDTH accumulator right by one.
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, ma} : '0);
        // Restoring division: WIDTH+1-bit trial remainder, since the shifted
        // remainder can reach 2*divisor-1.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, mb});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            ma       <= '0;
            mb       <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else if (accept) begin
            cnt      <= '0;
            is_div_q <= op[1];
            neg_a_q  <= a_neg_in;
            neg_b_q  <= b_neg_in;
            ma       <= a_mag;
            mb       <= b_mag;
            acc_hi   <= '0;
            // Multiplier (mult) or dividend (div) is shifted out of acc_lo.
            acc_lo   <= op[1] ? a_mag : b_mag;
        end else if (state == ST_RUN) begin
            cnt <= last_iter ? '0 : cnt + 1'b1;
            if (is_div_q) begin
                // Remainder always fits WIDTH bits after the step (< divisor,
                // or a prefix of the dividend when the divisor is zero).
                acc_hi <= div_ok ? WIDTH'(div_shift - {1'b0, mb}) : div_shift[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
            end else begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .is_div   (is_div_q),
        .neg_a    (neg_a_q),
        .neg_b    (neg_b_q),
        .div_zero (mb == '0),
        .prod     ({acc_hi, acc_lo}),
        .quot     (acc_lo),
        .rem      (acc_hi),
        .hi_fix   (fix_hi),
        .lo_fix   (fix_lo)
    );

    // ---------------- architectural HI/LO ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == ST_FIN);
            if (state == ST_FIN) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end else if (state == ST_IDLE && !start) begin
                // A write coinciding with an accepted start is dropped.
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
    import cpu_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    md_state_e   dbg_state;

    int          checks;
    int          passed;
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    vec_t        vecs[11];

    mul_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Starts one operation at the current negedge and returns at the negedge
    // where done is first seen (or when the cycle budget runs out).
    // inj_kind: 1 = extra start pulse, 2 = MTHI/MTLO write, at lat == inj_cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input string nm,
                          input int inj_cycle, input int inj_kind, input bit with_we);
        int lat;
        bit busy_ok;
        bit hold_ok;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (with_we) begin
            hi_we = 1'b1;
            wdata = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check({nm, "/busy_after_start"}, 32'(busy), 32'd1);
        check({nm, "/done_low_after_start"}, 32'(done), 32'd0);
        check({nm, "/hi_not_written"}, hi, model_hi);
        lat     = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!done && lat < 60) begin
            if (lat == inj_cycle && inj_kind == 1) begin
                start = 1'b1;
                op    = MD_DIVU;
                a     = 32'd1000;
                b     = 32'd3;
            end else if (lat == inj_cycle && inj_kind == 2) begin
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = 32'h0BAD_F00D;
            end
            @(negedge clk);
            start = 1'b0;
            hi_we = 1'b0;
            lo_we = 1'b0;
            lat++;
            if (!done) begin
                if (!busy) busy_ok = 1'b0;
                if (hi !== model_hi || lo !== model_lo) hold_ok = 1'b0;
            end
        end
        check({nm, "/latency"}, 32'(lat), 32'(MD_LATENCY));
        check({nm, "/busy_during_run"}, 32'(busy_ok), 32'd1);
        check({nm, "/hilo_hold_during_run"}, 32'(hold_ok), 32'd1);
        check({nm, "/busy_low_at_done"}, 32'(busy), 32'd0);
        check({nm, "/hi"}, hi, eh);
        check({nm, "/lo"}, lo, el);
        model_hi = eh;
        model_lo = el;
    endtask

    initial begin
        int  lat;
        bit  seen_done;
        checks   = 0;
        passed   = 0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        a        = 32'd0;
        b        = 32'd0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        wdata    = 32'd0;

        vecs[0]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
        vecs[1]  = '{MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7"};
        vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2"};
        vecs[3]  = '{MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu_100by7"};
        vecs[4]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_by_m1"};
        vecs[5]  = '{MD_DIVU,  32'd55,        32'd0,         32'd55,        32'hFFFF_FFFF, "divu_by_zero"};
        vecs[6]  = '{MD_DIV,   32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, "div_neg_by_zero"};
        vecs[7]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min_sq"};
        vecs[8]  = '{MD_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, "multu_shift4"};
        vecs[9]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_7by_neg2"};
        vecs[10] = '{MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         "mult_m1xm1"};

        // ---------------- reset ----------------
        #1;
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/done", 32'(done), 32'd0);
        check("reset/hi", hi, 32'd0);
        check("reset/lo", lo, 32'd0);
        check("reset/state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- MTHI / MTLO ----------------
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi/hi", hi, 32'h0000_1234);
        check("mthi/lo", lo, 32'd0);
        check("mthi/busy", 32'(busy), 32'd0);
        lo_we = 1'b1;
        wdata = 32'h0000_ABCD;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo/lo", lo, 32'h0000_ABCD);
        check("mtlo/hi", hi, 32'h0000_1234);
        check("mtlo/busy", 32'(busy), 32'd0);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthi_mtlo/hi", hi, 32'h5A5A_5A5A);
        check("mthi_mtlo/lo", lo, 32'h5A5A_5A5A);
        model_hi = 32'h5A5A_5A5A;
        model_lo = 32'h5A5A_5A5A;

        // ---------------- table-driven operations ----------------
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name, -1, 0, 1'b0);
            @(negedge clk);
            check({vecs[i].name, "/done_one_cycle"}, 32'(done), 32'd0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // ---------------- handshake collisions ----------------
        run_op(MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "start_during_run", 10, 1, 1'b0);
        @(negedge clk);
        check("start_during_run/done_one_cycle", 32'(done), 32'd0);
        check("start_during_run/not_queued", 32'(busy), 32'd0);

        run_op(MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "we_during_run", 12, 2, 1'b0);
        @(negedge clk);

        // start + MTHI in the same IDLE cycle, then a back-to-back start on done
        run_op(MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, "start_with_we", -1, 0, 1'b1);
        run_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "back_to_back", -1, 0, 1'b0);
        @(negedge clk);
        check("back_to_back/done_one_cycle", 32'(done), 32'd0);

        // ---------------- reset mid-operation ----------------
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0000_7777;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        start = 1'b1;
        op    = MD_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        check("midreset/busy_before", 32'(busy), 32'd1);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset/busy", 32'(busy), 32'd0);
        check("midreset/done", 32'(done), 32'd0);
        check("midreset/hi", hi, 32'd0);
        check("midreset/lo", lo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
            lat++;
        end
        check("midreset/no_done_after", 32'(seen_done), 32'd0);
        check("midreset/hi_after", hi, 32'd0);
        check("midreset/lo_after", lo, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
